// File: rtl/seven_seg_scheduler.sv
// Refresh-strobe generator and frame-source arbiter for a 4-digit multiplexed
// seven-segment display: base value, one-shot held message with blank gap, and per-digit blink.
module seven_seg_scheduler #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned BLINK_TICKS = 250,
    parameter int unsigned HOLD_TICKS  = 2000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] base_value,
    input  logic        msg_valid,
    input  logic [15:0] msg_value,
    output logic        msg_ready,
    input  logic        blink_en,
    input  logic [3:0]  blink_mask,
    output logic        refresh_tick,
    output logic [15:0] display_value,
    output logic [3:0]  digit_blank,
    output logic        msg_active
);

    localparam int unsigned REF_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned BLK_W  = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    // One extra code point so the counter can hold HOLD_TICKS itself.
    localparam int unsigned HOLD_W = $clog2(HOLD_TICKS + 1);

    localparam logic [REF_W-1:0]  REF_LAST  = REF_W'(REFRESH_DIV - 1);
    localparam logic [BLK_W-1:0]  BLK_LAST  = BLK_W'(BLINK_TICKS - 1);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_TICKS);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHOW,
        S_GAP
    } state_e;

    logic [REF_W-1:0]  ref_cnt_q, ref_cnt_d;
    logic              tick_q, tick_d;
    logic [BLK_W-1:0]  blink_cnt_q, blink_cnt_d;
    logic              blink_phase_q, blink_phase_d;
    state_e            state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [15:0]       msg_q, msg_d;
    logic [15:0]       disp_q, disp_d;
    logic [3:0]        blank_q, blank_d;

    always_comb begin
        ref_cnt_d = (ref_cnt_q == REF_LAST) ? '0 : ref_cnt_q + 1'b1;
        tick_d    = (ref_cnt_q == REF_LAST);
    end

    always_comb begin
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (tick_q) begin
            if (blink_cnt_q == BLK_LAST) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        msg_d   = msg_q;
        unique case (state_q)
            S_IDLE: begin
                if (msg_valid) begin
                    msg_d   = msg_value;
                    hold_d  = HOLD_INIT;
                    state_d = S_SHOW;
                end
            end
            S_SHOW: begin
                if (tick_q) begin
                    if (hold_q == HOLD_ONE) begin
                        state_d = S_GAP;
                    end else begin
                        hold_d = hold_q - 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (tick_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Frame source follows the state seen at the strobe, so an accept coinciding
    // with a strobe still shows base_value for that period.
    always_comb begin
        disp_d  = disp_q;
        blank_d = blank_q;
        if (tick_q) begin
            unique case (state_q)
                S_IDLE: begin
                    disp_d  = base_value;
                    blank_d = (blink_en && blink_phase_q) ? blink_mask : 4'h0;
                end
                S_SHOW: begin
                    disp_d  = msg_q;
                    blank_d = 4'h0;
                end
                S_GAP: begin
                    blank_d = 4'hF;
                end
                default: begin
                    disp_d  = disp_q;
                    blank_d = blank_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ref_cnt_q     <= '0;
            tick_q        <= 1'b0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            state_q       <= S_IDLE;
            hold_q        <= '0;
            msg_q         <= '0;
            disp_q        <= '0;
            blank_q       <= '1;
        end else begin
            ref_cnt_q     <= ref_cnt_d;
            tick_q        <= tick_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            state_q       <= state_d;
            hold_q        <= hold_d;
            msg_q         <= msg_d;
            disp_q        <= disp_d;
            blank_q       <= blank_d;
        end
    end

    assign refresh_tick  = tick_q;
    assign display_value = disp_q;
    assign digit_blank   = blank_q;
    assign msg_ready     = (state_q == S_IDLE);
    assign msg_active    = (state_q == S_SHOW);

endmodule

// File: tb/tb_seven_seg_scheduler.sv
// Bench for seven_seg_scheduler: expected frames are queued as stimulus is applied
// and checked by a monitor on each frame update; status outputs are checked inline.
module tb_seven_seg_scheduler;

    typedef struct {
        logic [15:0] disp;
        logic [3:0]  blank;
    } frame_t;

    typedef struct {
        logic       en;
        logic [3:0] mask;
        logic [3:0] blank;
    } blink_vec_t;

    logic        clk;
    logic        reset_n;
    logic [15:0] base_value;
    logic        msg_valid;
    logic [15:0] msg_value;
    logic        msg_ready;
    logic        blink_en;
    logic [3:0]  blink_mask;
    logic        refresh_tick;
    logic [15:0] display_value;
    logic [3:0]  digit_blank;
    logic        msg_active;

    logic [15:0] base1;
    logic        msg_valid1;
    logic [15:0] msg_value1;
    logic        ready1;
    logic        blink_en1;
    logic [3:0]  blink_mask1;
    logic        tick1;
    logic [15:0] disp1;
    logic [3:0]  blank1;
    logic        active1;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    frame_t      exp_q[$];
    frame_t      mon_f;
    logic        frame_due = 1'b0;

    seven_seg_scheduler #(
        .REFRESH_DIV(4),
        .BLINK_TICKS(2),
        .HOLD_TICKS (3)
    ) u_dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .base_value   (base_value),
        .msg_valid    (msg_valid),
        .msg_value    (msg_value),
        .msg_ready    (msg_ready),
        .blink_en     (blink_en),
        .blink_mask   (blink_mask),
        .refresh_tick (refresh_tick),
        .display_value(display_value),
        .digit_blank  (digit_blank),
        .msg_active   (msg_active)
    );

    seven_seg_scheduler #(
        .REFRESH_DIV(1),
        .BLINK_TICKS(1),
        .HOLD_TICKS (1)
    ) u_div1 (
        .clk          (clk),
        .reset_n      (reset_n),
        .base_value   (base1),
        .msg_valid    (msg_valid1),
        .msg_value    (msg_value1),
        .msg_ready    (ready1),
        .blink_en     (blink_en1),
        .blink_mask   (blink_mask1),
        .refresh_tick (tick1),
        .display_value(disp1),
        .digit_blank  (blank1),
        .msg_active   (active1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic push(input logic [15:0] d, input logic [3:0] b);
        frame_t f;
        f.disp  = d;
        f.blank = b;
        exp_q.push_back(f);
    endtask

    task automatic wait_q(input int n, input string nm);
        int unsigned budget = 0;
        while (exp_q.size() > n && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        checks++;
        if (exp_q.size() > n) begin
            failures++;
            $display("FAIL %s: timeout with %0d frames outstanding, required %0d", nm, exp_q.size(), n);
            exp_q.delete();
        end
    endtask

    // A strobe seen after edge k updates the frame at edge k+1.
    always @(posedge clk) begin
        #2;
        if (frame_due && exp_q.size() > 0) begin
            mon_f = exp_q.pop_front();
            chk("frame_display_value", 32'(display_value), 32'(mon_f.disp));
            chk("frame_digit_blank", 32'(digit_blank), 32'(mon_f.blank));
        end
        frame_due = refresh_tick && reset_n;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        blink_vec_t vecs[8];
        vecs = '{
            '{1'b1, 4'h5, 4'h0}, '{1'b1, 4'h5, 4'h0},
            '{1'b1, 4'h5, 4'h5}, '{1'b1, 4'h5, 4'h5},
            '{1'b1, 4'h5, 4'h0}, '{1'b1, 4'h5, 4'h0},
            '{1'b1, 4'hA, 4'hA}, '{1'b0, 4'hA, 4'h0}
        };

        reset_n     = 1'b0;
        base_value  = 16'h1234;
        msg_valid   = 1'b0;
        msg_value   = 16'h0000;
        blink_en    = 1'b0;
        blink_mask  = 4'h0;
        base1       = 16'h0F0F;
        msg_valid1  = 1'b0;
        msg_value1  = 16'h0000;
        blink_en1   = 1'b1;
        blink_mask1 = 4'hF;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_display_value", 32'(display_value), 32'h0000);
        chk("rst_digit_blank", 32'(digit_blank), 32'hF);
        chk("rst_refresh_tick", 32'(refresh_tick), 32'h0);
        chk("rst_msg_active", 32'(msg_active), 32'h0);
        chk("rst_msg_ready", 32'(msg_ready), 32'h1);

        // Refresh period and frame sync
        push(16'h1234, 4'h0);
        push(16'h1234, 4'h0);
        push(16'hBEEF, 4'h0);
        reset_n = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            chk($sformatf("tick_cycle_%0d", k), 32'(refresh_tick), 32'(k % 4 == 0));
            if (k <= 4) begin
                chk($sformatf("dark_disp_cycle_%0d", k), 32'(display_value), 32'h0000);
                chk($sformatf("dark_blank_cycle_%0d", k), 32'(digit_blank), 32'hF);
            end
            if (k == 10) base_value = 16'hBEEF;
            if (k == 12) chk("frame_sync_hold", 32'(display_value), 32'h1234);
            if (k <= 4) chk($sformatf("div1_tick_cycle_%0d", k), 32'(tick1), 32'h1);
            if (k == 1) begin
                chk("div1_disp_c1", 32'(disp1), 32'h0000);
                chk("div1_blank_c1", 32'(blank1), 32'hF);
                chk("div1_ready", 32'(ready1), 32'h1);
                chk("div1_active", 32'(active1), 32'h0);
            end
            if (k == 2) begin
                chk("div1_disp_c2", 32'(disp1), 32'h0F0F);
                chk("div1_blank_c2", 32'(blank1), 32'h0);
                base1 = 16'h0A0A;
            end
            if (k == 3) begin
                chk("div1_disp_c3", 32'(disp1), 32'h0A0A);
                chk("div1_blank_c3", 32'(blank1), 32'hF);
            end
            if (k == 4) chk("div1_blank_c4", 32'(blank1), 32'h0);
        end
        wait_q(0, "phase_refresh");

        // Message, busy request held through SHOW/GAP, retracted request
        msg_value = 16'hC0DE;
        msg_valid = 1'b1;
        chk("ready_before_accept", 32'(msg_ready), 32'h1);
        repeat (3) push(16'hC0DE, 4'h0);
        push(16'hC0DE, 4'hF);
        @(negedge clk);
        chk("ready_after_accept", 32'(msg_ready), 32'h0);
        chk("active_after_accept", 32'(msg_active), 32'h1);
        msg_value = 16'h1111;
        repeat (3) push(16'h1111, 4'h0);
        push(16'h1111, 4'hF);
        push(16'hBEEF, 4'h0);
        wait_q(6, "msg1_show");
        chk("gap_ready", 32'(msg_ready), 32'h0);
        chk("gap_active", 32'(msg_active), 32'h0);
        wait_q(5, "msg1_gap");
        chk("idle_ready_after_gap", 32'(msg_ready), 32'h1);
        @(negedge clk);
        chk("busy_req_accepted_ready", 32'(msg_ready), 32'h0);
        chk("busy_req_accepted_active", 32'(msg_active), 32'h1);
        msg_valid = 1'b0;
        @(negedge clk);
        msg_value = 16'h9999;
        msg_valid = 1'b1;
        @(negedge clk);
        msg_valid = 1'b0;
        wait_q(0, "msg2");
        chk("ready_after_msg2", 32'(msg_ready), 32'h1);
        chk("active_after_msg2", 32'(msg_active), 32'h0);

        // Async reset mid-SHOW
        msg_value = 16'h5A5A;
        msg_valid = 1'b1;
        push(16'h5A5A, 4'h0);
        @(negedge clk);
        msg_valid = 1'b0;
        wait_q(0, "msg3_show");
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_display_value", 32'(display_value), 32'h0000);
        chk("async_rst_digit_blank", 32'(digit_blank), 32'hF);
        chk("async_rst_refresh_tick", 32'(refresh_tick), 32'h0);
        chk("async_rst_msg_active", 32'(msg_active), 32'h0);
        chk("async_rst_msg_ready", 32'(msg_ready), 32'h1);
        base_value = 16'h4321;

        // Blink table; first strobe after release also shows there is no gap
        for (int i = 0; i < 8; i++) begin
            blink_en   = vecs[i].en;
            blink_mask = vecs[i].mask;
            push(16'h4321, vecs[i].blank);
            if (i == 0) begin
                @(negedge clk);
                reset_n = 1'b1;
                @(negedge clk);
                chk("post_rst_active", 32'(msg_active), 32'h0);
                chk("post_rst_ready", 32'(msg_ready), 32'h1);
            end
            wait_q(0, $sformatf("blink_vec_%0d", i));
        end

        // Blink suppressed during SHOW, forced blank in GAP, resumes in IDLE
        blink_en   = 1'b1;
        blink_mask = 4'hF;
        msg_value  = 16'h6E6E;
        msg_valid  = 1'b1;
        repeat (3) push(16'h6E6E, 4'h0);
        push(16'h6E6E, 4'hF);
        push(16'h4321, 4'h0);
        push(16'h4321, 4'h0);
        push(16'h4321, 4'hF);
        @(negedge clk);
        msg_valid = 1'b0;
        chk("pulse_accept_active", 32'(msg_active), 32'h1);
        wait_q(0, "blink_show");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seven_seg_scheduler.md
Name: seven_seg_scheduler

Overview:
Sequencing and source-arbitration front end for the 4-digit multiplexed seven-segment controller. It generates the single-cycle refresh strobe that steps the digit scan, and selects the 16-bit frame sent to the display. The frame source is either the always-present base value (e.g. clock/score) or a one-shot message from a valid/ready requester, which is held for a fixed time and followed by a blank gap. It also applies per-digit blinking and frame-synchronous updates, so digits never tear mid-scan.

Parameters:
REFRESH_DIV, 100000, clk cycles per refresh strobe (>=1; default gives 1 kHz at 100 MHz)
BLINK_TICKS, 250, refresh strobes per blink half-period (>=1)
HOLD_TICKS, 2000, refresh strobes a message stays on the display (>=1)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
base_value  in  16  default frame, 4 hex digits, [3:0] is the rightmost digit
msg_valid  in  1  message request
msg_value  in  16  message frame; sampled only on accept
msg_ready  out  1  high while the scheduler can accept a message
blink_en  in  1  global blink enable
blink_mask  in  4  digits to blink; bit i corresponds to digit i (bit 0 is rightmost)
refresh_tick  out  1  one-cycle strobe that clocks/enables the digit scan
display_value  out  16  registered frame to the display controller
digit_blank  out  4  registered per-digit blank; 1 means the digit is forced off
msg_active  out  1  high in SHOW state

Behaviour:
- Reset (async assert, sync release) sets these values:
  - refresh counter = 0, refresh_tick = 0
  - blink counter = 0, blink_phase = 0
  - state = IDLE, hold counter = 0
  - display_value = 16'h0000, digit_blank = 4'hF (dark until the first strobe), msg_active = 0
  - msg_ready = 1 after release
- Reset mid-message discards the message and does not produce a gap.
- Refresh counter:
  - Counts 0..REFRESH_DIV-1 and wraps to 0.
  - refresh_tick is registered and is high for exactly the one cycle after the counter reaches REFRESH_DIV-1.
  - Period is REFRESH_DIV cycles. With REFRESH_DIV=1, refresh_tick stays high continuously.
- Blink:
  - The blink counter advances on refresh_tick only, counting 0..BLINK_TICKS-1.
  - On wrap, blink_phase toggles.
  - The blink counter runs in every state.
- FSM states: IDLE, SHOW, GAP.
  - IDLE: msg_ready = 1. If msg_valid is high, the message is accepted: latch msg_value, load hold = HOLD_TICKS, go to SHOW.
  - SHOW: msg_ready = 0 and msg_valid is ignored. On each refresh_tick: if hold == 1, go to GAP; else decrement hold.
  - GAP: msg_ready = 0. On the next refresh_tick, go to IDLE.
  - msg_ready is a combinational decode of state.
  - A request that drops before being accepted has no effect.
- Frame register (updated only in cycles where refresh_tick = 1; the new value is visible the following cycle). Its source is chosen from the current state:
  - IDLE: display_value = base_value; digit_blank = (blink_en & blink_phase) ? blink_mask : 4'h0.
  - SHOW: display_value = latched message; digit_blank = 4'h0 (no blinking).
  - GAP: display_value unchanged; digit_blank = 4'hF.
- Simultaneous accept and refresh_tick: that strobe uses the IDLE source (base_value), and hold is not decremented. The message appears on the next strobe.
- Message display duration: the message is on the display for exactly HOLD_TICKS strobe periods. It is followed by exactly one blank strobe period, and then base_value returns.
- Changes to base_value between strobes do not appear on the outputs until the next strobe.
- Widths:
  - Counters are sized to clog2 of their parameter, minimum 1 bit.
  - No arithmetic overflow is permitted. Hold never decrements below 1.

Test Plan:
- Reset and refresh (REFRESH_DIV=4): release reset → refresh_tick pulses at cycles 4, 8, 12 (relative to release); digit_blank goes 4'hF→4'h0 and display_value 0→base_value=16'h1234 after the first strobe.
- Frame sync: change base_value to 16'hBEEF two cycles after a strobe → outputs still show 16'h1234 until the next strobe, then 16'hBEEF.
- Message (HOLD_TICKS=3): msg_valid with 16'hC0DE while IDLE → msg_ready drops next cycle; C0DE is shown for 3 strobes; then digit_blank=4'hF for 1 strobe; then base_value returns; msg_ready returns high.
- Busy and retract: msg_valid held during SHOW → not accepted; the request is accepted once IDLE is reached. A one-cycle msg_valid pulse while ready is accepted.
- Blink (BLINK_TICKS=2, blink_en=1, blink_mask=4'b0101): digit_blank sequence per strobe is 0,0,5,5,0,0; during SHOW it is forced to 0.
- Async reset mid-SHOW: assert reset_n=0 between edges → outputs go to reset values immediately; after release, state is IDLE and there is no gap.
